// File: rtl/r_debug_mw.sv
// r_debug_mw: host byte-stream to MIC read/write burst requester (WR, WR_SYNC, RD, PING, FILL).
// Optional R_DEBUG_MW_CSUM_EN: XOR checksum trailing write frames and appended to read replies.
module r_debug_mw #(
   parameter int ADDR_BYTES  = 4,
   parameter int MAX_WORDS   = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] O_TDATA,
   output logic        O_TVALID,
   output logic        O_TLAST,
   input  logic        O_TREADY,
   input  logic [63:0] I_TDATA,
   input  logic        I_TVALID,
   input  logic        I_TLAST,
   output logic        I_TREADY,
   output logic [7:0]  tx_data,
   output logic        tx_has_data,
   input  logic        tx_data_consume,
   input  logic [7:0]  rx_data,
   output logic        rx_has_space,
   input  logic        rx_data_produce,
   output logic        busy,
   output logic        err_sticky
);
`ifdef R_DEBUG_MW_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int WIDX = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [7:0] MAXW8 = 8'(MAX_WORDS);
   localparam logic [7:0] OP_WR = 8'h01, OP_RD = 8'h02, OP_WRS = 8'h03, OP_PING = 8'h04, OP_FILL = 8'h05;

   typedef enum logic [3:0] {IDLE, CNT, ADDR, PAYLOAD, MREQ, MRESP, TXDATA, TXACK, ERR} state_t;
   state_t state;

   logic [7:0]  op, n, bi, reply, nbeats, csum, rcsum;
   logic [31:0] addr, tcnt;
   logic [1:0]  acnt;
   logic [10:0] pcnt, plen;
   logic [31:0] wbuf [MAX_WORDS];
   logic [63:0] sr;
   logic [3:0]  sr_cnt;
   logic [8:0]  wrem, hi_w, lo_w;
   logic [31:0] hi_d, lo_d;
   logic        first, tmo, drain, tx_ld, sent, rx_ok, last_pay;

   assign rx_ok        = rx_data_produce && rx_has_space;
   assign rx_has_space = state inside {IDLE, CNT, ADDR, PAYLOAD};
   assign busy         = (state != IDLE);
   assign I_TREADY     = drain || (state == MRESP && (op != OP_RD || sr_cnt == 4'd0));
   assign plen         = (op == OP_FILL) ? 11'd4 : {1'b0, n, 2'b00};
   assign last_pay     = CSUM ? (pcnt == plen) : (pcnt == plen - 11'd1);
   // Beat count covers a leading half-beat when the start address sits in the upper word.
   assign nbeats       = 8'(({1'b0, n} + {8'd0, addr[2]} + 9'd1) >> 1);
   assign O_TLAST      = O_TVALID && ((op == OP_RD) ? (bi == 8'd0) : (bi == nbeats));

   // Header beat: {mic op, beats, first-beat BE, last-beat BE, 8-byte aligned address}.
   always_comb begin
      hi_w = {bi, 1'b0} - 9'd1 - {8'd0, addr[2]};
      lo_w = hi_w - 9'd1;
      hi_d = wbuf[0];
      lo_d = wbuf[0];
      if (op != OP_FILL) begin
         hi_d = (hi_w < 9'(MAX_WORDS)) ? wbuf[WIDX'(hi_w)] : 32'd0;
         lo_d = (lo_w < 9'(MAX_WORDS)) ? wbuf[WIDX'(lo_w)] : 32'd0;
      end
      if (bi == 8'd1 && addr[2]) lo_d = 32'd0;
      if (bi == 8'd0)
         O_TDATA = {((op == OP_RD) ? 8'h02 : 8'h01), nbeats,
                    (addr[2] ? 8'hF0 : 8'hFF), ((addr[2] ^ ~n[0]) ? 8'hFF : 8'h0F),
                    addr & 32'hFFFF_FFF8};
      else
         O_TDATA = {hi_d, lo_d};
   end

   always_ff @(posedge clk)
      if (state == PAYLOAD && rx_ok && pcnt < plen)
         wbuf[WIDX'(pcnt >> 2)][8*pcnt[1:0] +: 8] <= rx_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE; op <= '0; n <= '0; bi <= '0; reply <= '0; addr <= '0; acnt <= '0;
         pcnt <= '0; sr <= '0; sr_cnt <= '0; wrem <= '0; first <= 1'b0; tmo <= 1'b0;
         drain <= 1'b0; tx_ld <= 1'b0; sent <= 1'b0; tcnt <= '0; csum <= '0; rcsum <= '0;
         O_TVALID <= 1'b0; tx_data <= '0; tx_has_data <= 1'b0; err_sticky <= 1'b0;
      end else begin
         tx_ld <= 1'b0;
         if (tx_ld) tx_has_data <= 1'b1;
         else if (tx_data_consume) tx_has_data <= 1'b0;
         if (sr_cnt != 4'd0 && !tx_ld && !tx_has_data) begin
            tx_data <= sr[7:0];
            tx_ld   <= 1'b1;
            sr      <= sr >> 8;
            sr_cnt  <= sr_cnt - 4'd1;
            rcsum   <= rcsum ^ sr[7:0];
         end
         if (rx_ok) csum <= (state == IDLE) ? rx_data : (csum ^ rx_data);
         if (drain && I_TVALID && I_TLAST) drain <= 1'b0;

         case (state)
            IDLE: begin
               addr <= '0; tmo <= 1'b0; rcsum <= '0;
               if (rx_ok) begin
                  op <= rx_data;
                  if (rx_data == OP_PING) begin reply <= 8'hA5; state <= TXACK; end
                  else if (rx_data inside {OP_WR, OP_RD, OP_WRS, OP_FILL}) state <= CNT;
                  else state <= ERR;
               end
            end
            CNT: if (rx_ok) begin
               n <= rx_data; acnt <= '0;
               state <= (rx_data == 8'd0 || rx_data > MAXW8) ? ERR : ADDR;
            end
            ADDR: if (rx_ok) begin
               addr[8*acnt +: 8] <= rx_data;
               acnt <= acnt + 2'd1;
               if (acnt == 2'(ADDR_BYTES - 1)) begin
                  pcnt <= '0; bi <= '0;
                  if (op == OP_RD) begin O_TVALID <= 1'b1; state <= MREQ; end
                  else state <= PAYLOAD;
               end
            end
            PAYLOAD: if (rx_ok) begin
               pcnt <= pcnt + 11'd1;
               if (last_pay) begin
                  if (CSUM && (csum ^ rx_data) != 8'd0) begin
                     reply <= 8'h55; err_sticky <= 1'b1; state <= TXACK;
                  end else begin
                     O_TVALID <= 1'b1; state <= MREQ;
                  end
               end
            end
            MREQ: if (O_TREADY) begin
               if (O_TLAST) begin
                  O_TVALID <= 1'b0; state <= MRESP; tcnt <= '0; first <= 1'b1; wrem <= {1'b0, n};
               end else bi <= bi + 8'd1;
            end
            MRESP: begin
               if (I_TVALID && I_TREADY && !drain) begin
                  tcnt <= '0;
                  if (op == OP_RD) begin
                     first <= 1'b0;
                     if (first && addr[2]) begin
                        sr <= {32'd0, I_TDATA[63:32]}; sr_cnt <= 4'd4; wrem <= wrem - 9'd1;
                     end else if (wrem >= 9'd2) begin
                        sr <= I_TDATA; sr_cnt <= 4'd8; wrem <= wrem - 9'd2;
                     end else if (wrem != 9'd0) begin
                        sr <= {32'd0, I_TDATA[31:0]}; sr_cnt <= 4'd4; wrem <= 9'd0;
                     end
                     if (I_TLAST) state <= TXDATA;
                  end else if (I_TLAST) begin
                     if (op == OP_WRS) begin reply <= 8'hAA; state <= TXACK; end
                     else state <= IDLE;
                  end
               end else if (TIMEOUT_CYC != 0 && !I_TVALID) begin
                  if (tcnt == 32'(TIMEOUT_CYC - 1)) begin
                     // Abandon the burst; whatever the completer still sends gets swallowed.
                     err_sticky <= 1'b1; drain <= 1'b1; tmo <= 1'b1;
                     if (op == OP_RD) state <= TXDATA;
                     else if (op == OP_WRS) begin reply <= 8'hEE; state <= TXACK; end
                     else state <= IDLE;
                  end else tcnt <= tcnt + 32'd1;
               end
            end
            TXDATA: if (sr_cnt == 4'd0 && !tx_ld && !tx_has_data) begin
               if (wrem != 9'd0) begin
                  sr <= '0; sr_cnt <= 4'd4; wrem <= wrem - 9'd1;
               end else if (tmo) begin reply <= 8'hEE; state <= TXACK; end
               else if (CSUM) begin reply <= rcsum; state <= TXACK; end
               else state <= IDLE;
            end
            TXACK, ERR: begin
               if (!sent && !tx_ld && !tx_has_data) begin
                  tx_data <= (state == ERR) ? 8'hEE : reply;
                  tx_ld   <= 1'b1;
                  sent    <= 1'b1;
                  if (state == ERR) err_sticky <= 1'b1;
               end else if (sent && !tx_ld && !tx_has_data) begin
                  sent <= 1'b0; state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_r_debug_mw.sv
// Directed bench for r_debug_mw with a behavioural MIC memory completer.
module tb_r_debug_mw;
   logic        clk = 1'b0, reset = 1'b1;
   logic [63:0] O_TDATA, I_TDATA = '0;
   logic        O_TVALID, O_TLAST, O_TREADY = 1'b0;
   logic        I_TVALID = 1'b0, I_TLAST = 1'b0, I_TREADY;
   logic [7:0]  tx_data, rx_data = '0;
   logic        tx_has_data, tx_data_consume = 1'b0, rx_has_space, rx_data_produce = 1'b0;
   logic        busy, err_sticky;
   int          checks = 0, errors = 0;

   r_debug_mw #(.ADDR_BYTES(4), .MAX_WORDS(16), .TIMEOUT_CYC(150)) dut (
      .clk(clk), .reset(reset),
      .O_TDATA(O_TDATA), .O_TVALID(O_TVALID), .O_TLAST(O_TLAST), .O_TREADY(O_TREADY),
      .I_TDATA(I_TDATA), .I_TVALID(I_TVALID), .I_TLAST(I_TLAST), .I_TREADY(I_TREADY),
      .tx_data(tx_data), .tx_has_data(tx_has_data), .tx_data_consume(tx_data_consume),
      .rx_data(rx_data), .rx_has_space(rx_has_space), .rx_data_produce(rx_data_produce),
      .busy(busy), .err_sticky(err_sticky));

   always #5 clk = ~clk;

   // MIC completer: 64-bit word memory honouring first/last beat byte enables.
   logic [63:0] mem [int unsigned];
   logic [64:0] rq[$];
   bit          stall_resp = 1'b0, in_wr = 1'b0, hold_prev = 1'b0;
   int          cyc = 0, wb = 0, nb = 0;
   int unsigned base = 0;
   logic [7:0]  fbe = '0, lbe = '0, be;
   logic [63:0] prev_o = '0, wv;

   function automatic logic [63:0] rdm(input int unsigned idx);
      return mem.exists(idx) ? mem[idx] : 64'd0;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (hold_prev) begin
         checks++;
         assert (O_TVALID === 1'b1 && O_TDATA === prev_o)
         else begin errors++; $error("FAIL req_hold observed %h expected %h", O_TDATA, prev_o); end
      end
      hold_prev = O_TVALID && !O_TREADY;
      prev_o = O_TDATA;
      if (I_TVALID && I_TREADY) void'(rq.pop_front());
      if (O_TVALID && O_TREADY) begin
         if (!in_wr) begin
            nb = int'(O_TDATA[55:48]); fbe = O_TDATA[47:40]; lbe = O_TDATA[39:32];
            base = O_TDATA[31:0] >> 3;
            if (O_TDATA[63:56] == 8'h01) begin in_wr = 1'b1; wb = 0; end
            else for (int k = 0; k < nb; k++) rq.push_back({k == nb - 1, rdm(base + k)});
         end else begin
            be = 8'hFF;
            if (wb == 0) be &= fbe;
            if (wb == nb - 1) be &= lbe;
            wv = rdm(base + wb);
            for (int j = 0; j < 8; j++) if (be[j]) wv[8*j +: 8] = O_TDATA[8*j +: 8];
            mem[base + wb] = wv;
            wb++;
            if (O_TLAST) begin in_wr = 1'b0; rq.push_back({1'b1, 64'd0}); end
         end
      end
      O_TREADY <= (cyc % 3) != 1;
      if (rq.size() > 0 && !stall_resp) begin
         I_TVALID <= 1'b1; {I_TLAST, I_TDATA} <= rq[0];
      end else I_TVALID <= 1'b0;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin errors++; $error("FAIL %s observed %h expected %h", tag, got, exp); end
   endtask

   task automatic put(input logic [7:0] b);
      int t = 0;
      while (!rx_has_space && t < 2000) begin @(negedge clk); t++; end
      if (!rx_has_space) chk("rx_space_wait", 64'd0, 64'd1);
      rx_data = b; rx_data_produce = 1'b1;
      @(negedge clk);
      rx_data_produce = 1'b0;
   endtask

   task automatic put_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) put(w[8*i +: 8]);
   endtask

   task automatic cmd(input logic [7:0] op, input logic [7:0] n, input logic [31:0] a);
      put(op); put(n); put_word(a);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      int t = 0;
      logic [7:0] b;
      while (!tx_has_data && t < 2000) begin @(negedge clk); t++; end
      b = 8'hxx;
      if (tx_has_data) begin
         b = tx_data; tx_data_consume = 1'b1;
         @(negedge clk);
         tx_data_consume = 1'b0;
      end
      chk(tag, {56'd0, b}, {56'd0, exp});
   endtask

   task automatic expect_word(input string tag, input logic [31:0] w);
      for (int i = 0; i < 4; i++) expect_byte(tag, w[8*i +: 8]);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 2000) begin @(negedge clk); t++; end
      chk(tag, {62'd0, busy, tx_has_data}, 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      mem[32'h20020 >> 3] = 64'h8877_6655_4433_2211;
      do_reset();
      chk("reset_outputs", {57'd0, O_TVALID, O_TLAST, I_TREADY, tx_has_data, busy, err_sticky, rx_has_space},
          64'h01);

      // Aligned write then readback
      cmd(8'h01, 8'd4, 32'h0001_2340);
      put_word(32'hdeadbeef); put_word(32'hfeedface); put_word(32'h12345678); put_word(32'hcafecace);
      wait_idle("wr_aligned_idle");
      chk("wr_aligned_mem0", rdm(32'h12340 >> 3), 64'hfeedface_deadbeef);
      chk("wr_aligned_mem1", rdm(32'h12348 >> 3), 64'hcafecace_12345678);
      cmd(8'h02, 8'd4, 32'h0001_2340);
      expect_word("rd_aligned", 32'hdeadbeef); expect_word("rd_aligned", 32'hfeedface);
      expect_word("rd_aligned", 32'h12345678); expect_word("rd_aligned", 32'hcafecace);
      wait_idle("rd_aligned_idle");

      // Mid-beat write then readback; preceding word must survive
      cmd(8'h01, 8'd4, 32'h0001_2344);
      for (int i = 0; i < 16; i++) put(8'(i));
      wait_idle("wr_mid_idle");
      chk("wr_mid_mem0", rdm(32'h12340 >> 3), 64'h03020100_deadbeef);
      chk("wr_mid_mem2", rdm(32'h12350 >> 3), 64'h00000000_0f0e0d0c);
      cmd(8'h02, 8'd4, 32'h0001_2344);
      for (int i = 0; i < 16; i++) expect_byte("rd_mid", 8'(i));
      cmd(8'h02, 8'd1, 32'h0001_2340);
      expect_word("rd_prev_word", 32'hdeadbeef);
      wait_idle("rd_prev_idle");

      // FILL, then readback and untouched neighbour
      cmd(8'h05, 8'd8, 32'h0002_0000);
      put_word(32'ha5a5a5a5);
      wait_idle("fill_idle");
      cmd(8'h02, 8'd8, 32'h0002_0000);
      for (int i = 0; i < 32; i++) expect_byte("rd_fill", 8'ha5);
      cmd(8'h02, 8'd2, 32'h0002_0020);
      expect_word("rd_untouched", 32'h44332211); expect_word("rd_untouched", 32'h88776655);

      // WR_SYNC at MAX_WORDS
      cmd(8'h03, 8'd16, 32'h0003_0000);
      for (int i = 0; i < 16; i++) put_word(32'h1000_0000 + 32'(i));
      expect_byte("wrsync_ack", 8'hAA);
      wait_idle("wrsync_idle");
      chk("wrsync_mem_last", rdm(32'h30038 >> 3), 64'h1000000f_1000000e);
      chk("wrsync_no_err", {63'd0, err_sticky}, 64'd0);
      put(8'h04);
      expect_byte("ping", 8'hA5);

      // Frame errors
      put(8'h03); put(8'd0);
      expect_byte("n_zero", 8'hEE);
      chk("n_zero_err", {63'd0, err_sticky}, 64'd1);
      wait_idle("n_zero_idle");
      do_reset();
      chk("err_cleared", {63'd0, err_sticky}, 64'd0);
      put(8'h03); put(8'd17);
      expect_byte("n_over", 8'hEE);
      chk("n_over_err", {63'd0, err_sticky}, 64'd1);
      do_reset();
      put(8'h09);
      expect_byte("bad_op", 8'hEE);
      chk("bad_op_err", {63'd0, err_sticky}, 64'd1);
      wait_idle("bad_op_idle");
      do_reset();

      // Read timeout with a stalled completer, then late-beat drain and recovery
      stall_resp = 1'b1;
      cmd(8'h02, 8'd2, 32'h0001_2340);
      for (int i = 0; i < 8; i++) expect_byte("tmo_pad", 8'h00);
      expect_byte("tmo_err", 8'hEE);
      chk("tmo_sticky", {63'd0, err_sticky}, 64'd1);
      stall_resp = 1'b0;
      repeat (20) @(negedge clk);
      chk("tmo_drained", 64'(rq.size()), 64'd0);
      chk("tmo_ready_low", {63'd0, I_TREADY}, 64'd0);
      put(8'h04);
      expect_byte("ping_after_tmo", 8'hA5);
      cmd(8'h02, 8'd1, 32'h0001_2340);
      expect_word("rd_after_tmo", 32'hdeadbeef);
      wait_idle("final_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "bench timeout");
   end
endmodule
